// File: rtl/dmem_ext_arbiter.sv
// Data-memory front-end: shares data_mem between the CPU load/store path and a host burst port.
// Optional macro DMEM_ARB_ABORT_EN adds ext_abort/ext_aborted for host-side burst cancellation.
module dmem_ext_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_adr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [2:0]        cpu_funct3,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ext_start,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_base,
    input  logic [LEN_W-1:0]  ext_len,
    input  logic              ext_valid,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic              ext_ready,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_rvalid,
    output logic              ext_busy,
    output logic              ext_done,
`ifdef DMEM_ARB_ABORT_EN
    input  logic              ext_abort,
    output logic              ext_aborted,
`endif
    output logic              mem_we,
    output logic [2:0]        mem_funct3,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BURST, DONE} stateT;

    stateT             state, stateNext;
    logic [ADDR_W-1:0] curAdr;
    logic [LEN_W-1:0]  remaining;
    logic              burstWe;
    logic              abortReq;
    logic              beat;

`ifdef DMEM_ARB_ABORT_EN
    logic abortedReg;
    assign abortReq    = ext_abort && (state == BURST);
    assign ext_aborted = (state == DONE) && abortedReg;
`else
    assign abortReq = 1'b0;
`endif

    // An abort steals the cycle, so no beat can coincide with it.
    assign beat = (state == BURST) && ext_valid && !abortReq;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            curAdr     <= '0;
            remaining  <= '0;
            burstWe    <= 1'b0;
            ext_rdata  <= '0;
            ext_rvalid <= 1'b0;
`ifdef DMEM_ARB_ABORT_EN
            abortedReg <= 1'b0;
`endif
        end else begin
            state      <= stateNext;
            ext_rvalid <= beat && !burstWe;
            if (beat && !burstWe) begin
                ext_rdata <= mem_rdata;
            end
            case (state)
                IDLE: begin
                    if (ext_start) begin
                        curAdr    <= ext_base & ~ADDR_W'(3);
                        remaining <= ext_len;
                        burstWe   <= ext_we;
`ifdef DMEM_ARB_ABORT_EN
                        abortedReg <= 1'b0;
`endif
                    end
                end
                BURST: begin
                    if (abortReq) begin
                        remaining <= '0;
`ifdef DMEM_ARB_ABORT_EN
                        abortedReg <= 1'b1;
`endif
                    end else if (beat) begin
                        curAdr    <= curAdr + ADDR_W'(4);
                        remaining <= remaining - LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // CPU owns the memory port only in IDLE; otherwise word accesses at curAdr.
    always_comb begin
        stateNext  = state;
        cpu_rdata  = mem_rdata;
        cpu_stall  = 1'b1;
        ext_ready  = 1'b0;
        ext_busy   = 1'b0;
        ext_done   = 1'b0;
        mem_we     = 1'b0;
        mem_funct3 = 3'b010;
        mem_adr    = curAdr;
        mem_wdata  = ext_wdata;
        case (state)
            IDLE: begin
                cpu_stall  = 1'b0;
                mem_we     = cpu_we;
                mem_funct3 = cpu_funct3;
                mem_adr    = cpu_adr;
                mem_wdata  = cpu_wdata;
                if (ext_start) begin
                    stateNext = (ext_len != '0) ? BURST : DONE;
                end
            end
            BURST: begin
                ext_busy  = 1'b1;
                ext_ready = !abortReq;
                mem_we    = beat && burstWe;
                if (abortReq || (beat && remaining == LEN_W'(1))) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                ext_done  = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dmem_ext_arbiter.sv
// Directed bench for dmem_ext_arbiter with a word-addressed stand-in for data_mem.
// Exercises the abort scenario as well when DMEM_ARB_ABORT_EN is defined.
module tb_dmem_ext_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 8;

    logic              clk;
    logic              reset;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_adr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [2:0]        cpu_funct3;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;
    logic              ext_start;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_base;
    logic [LEN_W-1:0]  ext_len;
    logic              ext_valid;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_ready;
    logic [DATA_W-1:0] ext_rdata;
    logic              ext_rvalid;
    logic              ext_busy;
    logic              ext_done;
`ifdef DMEM_ARB_ABORT_EN
    logic              ext_abort;
    logic              ext_aborted;
`endif
    logic              mem_we;
    logic [2:0]        mem_funct3;
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [31:0] mem [1024];
    int          writeCount;
    int          checks;
    int          failures;

    dmem_ext_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset),
        .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata), .cpu_funct3(cpu_funct3),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ext_start(ext_start), .ext_we(ext_we), .ext_base(ext_base), .ext_len(ext_len),
        .ext_valid(ext_valid), .ext_wdata(ext_wdata), .ext_ready(ext_ready),
        .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid), .ext_busy(ext_busy), .ext_done(ext_done),
`ifdef DMEM_ARB_ABORT_EN
        .ext_abort(ext_abort), .ext_aborted(ext_aborted),
`endif
        .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_adr(mem_adr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational-read, synchronous-write memory, aliased on address bits [11:2].
    assign mem_rdata = mem[mem_adr[11:2]];
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_adr[11:2]] <= mem_wdata;
            writeCount <= writeCount + 1;
        end
    end

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs;
        cpu_we = 0; cpu_adr = '0; cpu_wdata = '0; cpu_funct3 = 3'b010;
        ext_start = 0; ext_we = 0; ext_base = '0; ext_len = '0; ext_valid = 0; ext_wdata = '0;
`ifdef DMEM_ARB_ABORT_EN
        ext_abort = 0;
`endif
    endtask

    task automatic test_reset;
        idleInputs();
        reset = 1;
        nextCycle();
        nextCycle();
        cpu_adr = 32'h0000_0ABC; cpu_funct3 = 3'b001;
        @(negedge clk);
        checks++; if (ext_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_ready: got %0h expected 0", ext_ready); end
        checks++; if (ext_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL rst_rvalid: got %0h expected 0", ext_rvalid); end
        checks++; if (ext_rdata !== 32'h0) begin failures++; $display("[TB] FAIL rst_rdata: got %h expected 0", ext_rdata); end
        checks++; if (ext_done !== 1'b0) begin failures++; $display("[TB] FAIL rst_done: got %0h expected 0", ext_done); end
        checks++; if (ext_busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy: got %0h expected 0", ext_busy); end
        checks++; if (cpu_stall !== 1'b0) begin failures++; $display("[TB] FAIL rst_stall: got %0h expected 0", cpu_stall); end
        checks++; if (mem_adr !== 32'h0000_0ABC) begin failures++; $display("[TB] FAIL rst_passadr: got %h expected 00000abc", mem_adr); end
        checks++; if (mem_funct3 !== 3'b001) begin failures++; $display("[TB] FAIL rst_passf3: got %0h expected 1", mem_funct3); end
        nextCycle();
        reset = 0;
        idleInputs();
        nextCycle();
    endtask

    task automatic test_write_burst;
        int wc0;
        wc0 = writeCount;
        ext_start = 1; ext_we = 1; ext_base = 32'h103; ext_len = 8'd4; ext_valid = 1; ext_wdata = 32'hA0;
        @(negedge clk);
        checks++; if (cpu_stall !== 1'b0) begin failures++; $display("[TB] FAIL wr_startstall: got %0h expected 0", cpu_stall); end
        nextCycle();
        ext_start = 0;
        for (int i = 0; i < 4; i++) begin
            ext_wdata = 32'hA0 + i;
            @(negedge clk);
            checks++; if (mem_adr !== 32'h100 + 4 * i) begin failures++; $display("[TB] FAIL wr_adr%0d: got %h expected %h", i, mem_adr, 32'h100 + 4 * i); end
            checks++; if (mem_we !== 1'b1 || cpu_stall !== 1'b1 || ext_ready !== 1'b1 || ext_busy !== 1'b1) begin failures++; $display("[TB] FAIL wr_ctl%0d: got we=%0h stall=%0h ready=%0h busy=%0h expected all 1", i, mem_we, cpu_stall, ext_ready, ext_busy); end
            checks++; if (mem_funct3 !== 3'b010) begin failures++; $display("[TB] FAIL wr_f3_%0d: got %0h expected 2", i, mem_funct3); end
            nextCycle();
        end
        ext_valid = 0;
        @(negedge clk);
        checks++; if (ext_done !== 1'b1 || cpu_stall !== 1'b1 || mem_we !== 1'b0 || ext_busy !== 1'b0 || ext_ready !== 1'b0) begin failures++; $display("[TB] FAIL wr_donecyc: got done=%0h stall=%0h we=%0h busy=%0h ready=%0h expected 1 1 0 0 0", ext_done, cpu_stall, mem_we, ext_busy, ext_ready); end
        checks++; if (ext_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL wr_rvalid: got %0h expected 0", ext_rvalid); end
        nextCycle();
        @(negedge clk);
        checks++; if (cpu_stall !== 1'b0 || ext_done !== 1'b0) begin failures++; $display("[TB] FAIL wr_after: got stall=%0h done=%0h expected 0 0", cpu_stall, ext_done); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (mem[64 + i] !== 32'hA0 + i) begin failures++; $display("[TB] FAIL wr_mem%0d: got %h expected %h", i, mem[64 + i], 32'hA0 + i); end
        end
        checks++; if (writeCount - wc0 !== 4) begin failures++; $display("[TB] FAIL wr_count: got %0d expected 4", writeCount - wc0); end
        nextCycle();
    endtask

    task automatic test_read_bubble;
        int wc0;
        int vld [5]   = '{1, 0, 1, 1, 0};
        int expRv [5] = '{0, 1, 0, 1, 1};
        logic [31:0] expRd [5]  = '{32'h0, 32'h11, 32'h0, 32'h22, 32'h33};
        logic [31:0] expAdr [5] = '{32'h200, 32'h204, 32'h204, 32'h208, 32'h0};
        cpu_we = 1; cpu_adr = 32'h200; cpu_wdata = 32'h11; nextCycle();
        cpu_adr = 32'h204; cpu_wdata = 32'h22; nextCycle();
        cpu_adr = 32'h208; cpu_wdata = 32'h33; nextCycle();
        cpu_we = 0; cpu_adr = 32'h204;
        @(negedge clk);
        checks++; if (cpu_rdata !== 32'h22) begin failures++; $display("[TB] FAIL rd_cpuload: got %h expected 22", cpu_rdata); end
        wc0 = writeCount;
        ext_start = 1; ext_we = 0; ext_base = 32'h200; ext_len = 8'd3; ext_valid = 0;
        nextCycle();
        ext_start = 0;
        for (int i = 0; i < 5; i++) begin
            ext_valid = vld[i][0];
            @(negedge clk);
            checks++; if (ext_rvalid !== expRv[i][0]) begin failures++; $display("[TB] FAIL rd_rvalid%0d: got %0h expected %0h", i, ext_rvalid, expRv[i][0]); end
            if (expRv[i] == 1) begin
                checks++; if (ext_rdata !== expRd[i]) begin failures++; $display("[TB] FAIL rd_data%0d: got %h expected %h", i, ext_rdata, expRd[i]); end
            end
            if (i < 4) begin
                checks++; if (mem_adr !== expAdr[i] || mem_we !== 1'b0) begin failures++; $display("[TB] FAIL rd_adr%0d: got %h we=%0h expected %h we=0", i, mem_adr, mem_we, expAdr[i]); end
            end
            checks++; if (ext_done !== (i == 4)) begin failures++; $display("[TB] FAIL rd_done%0d: got %0h expected %0h", i, ext_done, i == 4); end
            nextCycle();
        end
        ext_valid = 0;
        @(negedge clk);
        checks++; if (ext_rvalid !== 1'b0 || cpu_stall !== 1'b0) begin failures++; $display("[TB] FAIL rd_after: got rvalid=%0h stall=%0h expected 0 0", ext_rvalid, cpu_stall); end
        checks++; if (writeCount - wc0 !== 0) begin failures++; $display("[TB] FAIL rd_nowrite: got %0d expected 0", writeCount - wc0); end
        nextCycle();
    endtask

    task automatic test_collision;
        int wc0;
        wc0 = writeCount;
        cpu_we = 1; cpu_adr = 32'h40; cpu_wdata = 32'h55;
        ext_start = 1; ext_we = 1; ext_base = 32'h40; ext_len = 8'd1; ext_valid = 1; ext_wdata = 32'h66;
        @(negedge clk);
        checks++; if (mem_we !== 1'b1 || mem_wdata !== 32'h55 || mem_adr !== 32'h40) begin failures++; $display("[TB] FAIL col_cpu: got we=%0h data=%h adr=%h expected 1 55 40", mem_we, mem_wdata, mem_adr); end
        nextCycle();
        ext_start = 0; cpu_adr = 32'h48; cpu_wdata = 32'h77;
        @(negedge clk);
        checks++; if (mem[16] !== 32'h55) begin failures++; $display("[TB] FAIL col_first: got %h expected 55", mem[16]); end
        checks++; if (mem_wdata !== 32'h66 || mem_adr !== 32'h40 || cpu_stall !== 1'b1) begin failures++; $display("[TB] FAIL col_host: got data=%h adr=%h stall=%0h expected 66 40 1", mem_wdata, mem_adr, cpu_stall); end
        nextCycle();
        ext_valid = 0;
        @(negedge clk);
        checks++; if (mem_we !== 1'b0 || ext_done !== 1'b1) begin failures++; $display("[TB] FAIL col_done: got we=%0h done=%0h expected 0 1", mem_we, ext_done); end
        checks++; if (mem[16] !== 32'h66) begin failures++; $display("[TB] FAIL col_final: got %h expected 66", mem[16]); end
        nextCycle();
        cpu_we = 0;
        checks++; if (writeCount - wc0 !== 2) begin failures++; $display("[TB] FAIL col_count: got %0d expected 2", writeCount - wc0); end
        nextCycle();
    endtask

    task automatic test_len_zero;
        int wc0;
        wc0 = writeCount;
        ext_start = 1; ext_we = 1; ext_base = 32'h80; ext_len = 8'd0; ext_valid = 1; ext_wdata = 32'hEE;
        nextCycle();
        ext_start = 0;
        @(negedge clk);
        checks++; if (ext_done !== 1'b1 || cpu_stall !== 1'b1 || mem_we !== 1'b0 || ext_busy !== 1'b0) begin failures++; $display("[TB] FAIL len0_done: got done=%0h stall=%0h we=%0h busy=%0h expected 1 1 0 0", ext_done, cpu_stall, mem_we, ext_busy); end
        nextCycle();
        ext_valid = 0;
        @(negedge clk);
        checks++; if (cpu_stall !== 1'b0 || ext_done !== 1'b0) begin failures++; $display("[TB] FAIL len0_after: got stall=%0h done=%0h expected 0 0", cpu_stall, ext_done); end
        checks++; if (writeCount - wc0 !== 0) begin failures++; $display("[TB] FAIL len0_count: got %0d expected 0", writeCount - wc0); end
        nextCycle();
    endtask

    task automatic test_wrap;
        ext_start = 1; ext_we = 1; ext_base = 32'hFFFF_FFFC; ext_len = 8'd2; ext_valid = 1; ext_wdata = 32'hB0;
        nextCycle();
        ext_start = 0;
        @(negedge clk);
        checks++; if (mem_adr !== 32'hFFFF_FFFC) begin failures++; $display("[TB] FAIL wrap_adr0: got %h expected fffffffc", mem_adr); end
        nextCycle();
        ext_wdata = 32'hB1;
        @(negedge clk);
        checks++; if (mem_adr !== 32'h0 || mem_we !== 1'b1) begin failures++; $display("[TB] FAIL wrap_adr1: got %h we=%0h expected 00000000 we=1", mem_adr, mem_we); end
        nextCycle();
        ext_valid = 0;
        @(negedge clk);
        checks++; if (ext_done !== 1'b1) begin failures++; $display("[TB] FAIL wrap_done: got %0h expected 1", ext_done); end
        checks++; if (mem[1023] !== 32'hB0 || mem[0] !== 32'hB1) begin failures++; $display("[TB] FAIL wrap_mem: got %h %h expected b0 b1", mem[1023], mem[0]); end
        nextCycle();
    endtask

    task automatic test_start_while_busy;
        ext_start = 1; ext_we = 1; ext_base = 32'h300; ext_len = 8'd3; ext_valid = 1; ext_wdata = 32'hD0;
        nextCycle();
        ext_start = 0;
        @(negedge clk);
        checks++; if (mem_adr !== 32'h300) begin failures++; $display("[TB] FAIL busy_adr0: got %h expected 300", mem_adr); end
        nextCycle();
        ext_wdata = 32'hD1; ext_start = 1; ext_base = 32'h3F0; ext_len = 8'd1; ext_we = 0;
        @(negedge clk);
        checks++; if (mem_adr !== 32'h304 || mem_we !== 1'b1) begin failures++; $display("[TB] FAIL busy_adr1: got %h we=%0h expected 304 we=1", mem_adr, mem_we); end
        nextCycle();
        ext_start = 0; ext_wdata = 32'hD2;
        @(negedge clk);
        checks++; if (mem_adr !== 32'h308 || mem_we !== 1'b1 || ext_busy !== 1'b1) begin failures++; $display("[TB] FAIL busy_adr2: got %h we=%0h busy=%0h expected 308 1 1", mem_adr, mem_we, ext_busy); end
        nextCycle();
        ext_valid = 0;
        @(negedge clk);
        checks++; if (ext_done !== 1'b1) begin failures++; $display("[TB] FAIL busy_done: got %0h expected 1", ext_done); end
        checks++; if (mem[192] !== 32'hD0 || mem[193] !== 32'hD1 || mem[194] !== 32'hD2) begin failures++; $display("[TB] FAIL busy_mem: got %h %h %h expected d0 d1 d2", mem[192], mem[193], mem[194]); end
        nextCycle();
        @(negedge clk);
        checks++; if (cpu_stall !== 1'b0 || ext_busy !== 1'b0) begin failures++; $display("[TB] FAIL busy_idle: got stall=%0h busy=%0h expected 0 0", cpu_stall, ext_busy); end
        nextCycle();
    endtask

    task automatic test_reset_mid_burst;
        int wc0;
        wc0 = writeCount;
        ext_start = 1; ext_we = 1; ext_base = 32'h120; ext_len = 8'd8; ext_valid = 1; ext_wdata = 32'hC0;
        nextCycle();
        ext_start = 0;
        for (int i = 0; i < 3; i++) begin
            ext_wdata = 32'hC0 + i;
            nextCycle();
        end
        reset = 1; ext_valid = 0;
        nextCycle();
        @(negedge clk);
        checks++; if (ext_busy !== 1'b0 || cpu_stall !== 1'b0 || ext_done !== 1'b0 || ext_ready !== 1'b0 || ext_rvalid !== 1'b0) begin failures++; $display("[TB] FAIL mid_rst: got busy=%0h stall=%0h done=%0h ready=%0h rvalid=%0h expected all 0", ext_busy, cpu_stall, ext_done, ext_ready, ext_rvalid); end
        nextCycle();
        reset = 0;
        @(negedge clk);
        checks++; if (ext_done !== 1'b0 || cpu_stall !== 1'b0) begin failures++; $display("[TB] FAIL mid_nodone: got done=%0h stall=%0h expected 0 0", ext_done, cpu_stall); end
        checks++; if (writeCount - wc0 !== 3) begin failures++; $display("[TB] FAIL mid_count: got %0d expected 3", writeCount - wc0); end
        checks++; if (mem[72] !== 32'hC0 || mem[73] !== 32'hC1 || mem[74] !== 32'hC2) begin failures++; $display("[TB] FAIL mid_mem: got %h %h %h expected c0 c1 c2", mem[72], mem[73], mem[74]); end
        nextCycle();
        ext_start = 1; ext_we = 1; ext_base = 32'h140; ext_len = 8'd1; ext_valid = 1; ext_wdata = 32'hE0;
        nextCycle();
        ext_start = 0;
        nextCycle();
        ext_valid = 0;
        @(negedge clk);
        checks++; if (ext_done !== 1'b1 || mem[80] !== 32'hE0) begin failures++; $display("[TB] FAIL mid_newburst: got done=%0h mem=%h expected 1 e0", ext_done, mem[80]); end
        nextCycle();
    endtask

`ifdef DMEM_ARB_ABORT_EN
    task automatic test_abort;
        int wc0;
        wc0 = writeCount;
        ext_start = 1; ext_we = 1; ext_base = 32'h160; ext_len = 8'd6; ext_valid = 1; ext_wdata = 32'hF0;
        nextCycle();
        ext_start = 0;
        nextCycle();
        ext_wdata = 32'hF1;
        nextCycle();
        ext_wdata = 32'hF2; ext_abort = 1;
        @(negedge clk);
        checks++; if (mem_we !== 1'b0 || ext_ready !== 1'b0 || ext_aborted !== 1'b0) begin failures++; $display("[TB] FAIL abt_cycle: got we=%0h ready=%0h aborted=%0h expected 0 0 0", mem_we, ext_ready, ext_aborted); end
        nextCycle();
        ext_abort = 0; ext_valid = 0;
        @(negedge clk);
        checks++; if (ext_done !== 1'b1 || ext_aborted !== 1'b1) begin failures++; $display("[TB] FAIL abt_done: got done=%0h aborted=%0h expected 1 1", ext_done, ext_aborted); end
        checks++; if (writeCount - wc0 !== 2) begin failures++; $display("[TB] FAIL abt_count: got %0d expected 2", writeCount - wc0); end
        nextCycle();
        @(negedge clk);
        checks++; if (ext_aborted !== 1'b0 || cpu_stall !== 1'b0) begin failures++; $display("[TB] FAIL abt_after: got aborted=%0h stall=%0h expected 0 0", ext_aborted, cpu_stall); end
        nextCycle();
    endtask
`endif

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        failures = 0;
        reset = 1;
        idleInputs();
        test_reset();
        test_write_burst();
        test_read_bubble();
        test_collision();
        test_len_zero();
        test_wrap();
        test_start_while_busy();
        test_reset_mid_burst();
`ifdef DMEM_ARB_ABORT_EN
        test_abort();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
